// File: rtl/dmem_arb_pkg.sv
// Shared types for the dmem arbiter: FSM state, port owner, burst-counter width.
package dmem_arb_pkg;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      OWN_CORE = 2'd1,
      OWN_DBG  = 2'd2
   } arb_state_e;

   typedef enum logic [1:0] {
      NONE = 2'd0,
      CORE = 2'd1,
      DBG  = 2'd2
   } owner_e;

   function automatic int bcnt_w(input int max_burst);
      return $clog2(max_burst + 1);
   endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// Combinational grant selection for the dmem arbiter.
// With DMEM_ARB_RR_EN defined an IDLE tie alternates using `last`; otherwise core wins ties.
module dmem_arb_pick
   import dmem_arb_pkg::*;
#(
   parameter int MAX_BURST = 4,
   parameter int BW        = bcnt_w(MAX_BURST)
) (
   input  arb_state_e       state,
   input  logic [BW-1:0]    bcnt,
   input  logic             core_req,
   input  logic             dbg_req,
`ifdef DMEM_ARB_RR_EN
   input  owner_e           last,
`endif
   output owner_e           win
);

   localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

   always_comb begin
      win = NONE;
      case (state)
         IDLE: begin
            if (core_req && dbg_req) begin
`ifdef DMEM_ARB_RR_EN
               win = (last == CORE) ? DBG : CORE;
`else
               win = CORE;
`endif
            end else if (core_req) begin
               win = CORE;
            end else if (dbg_req) begin
               win = DBG;
            end
         end
         // Owner keeps the port until its burst is spent while the other side waits.
         OWN_CORE: begin
            if (core_req && (!dbg_req || bcnt < MAX_B)) win = CORE;
            else if (dbg_req)                           win = DBG;
         end
         OWN_DBG: begin
            if (dbg_req && (!core_req || bcnt < MAX_B)) win = DBG;
            else if (core_req)                          win = CORE;
         end
         default: win = NONE;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares a synchronous single-port dmem between the core and a debug/loader port.
// Optional build macro DMEM_ARB_RR_EN: round-robin IDLE ties via a `last` owner flop.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int AW        = 5,
   parameter int DW        = 32,
   parameter int MAX_BURST = 4
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             core_req,
   input  logic             core_we,
   input  logic [AW-1:0]    core_addr,
   input  logic [DW-1:0]    core_wdata,
   output logic             core_gnt,
   output logic             core_rvalid,
   output logic [DW-1:0]    core_rdata,
   input  logic             dbg_req,
   input  logic             dbg_we,
   input  logic [AW-1:0]    dbg_addr,
   input  logic [DW-1:0]    dbg_wdata,
   output logic             dbg_gnt,
   output logic             dbg_rvalid,
   output logic [DW-1:0]    dbg_rdata,
   output logic             mem_en,
   output logic             mem_we,
   output logic [AW-1:0]    mem_addr,
   output logic [DW-1:0]    mem_wdata,
   input  logic [DW-1:0]    mem_rdata,
   output arb_state_e       arb_state
);

   // Handshake: a port's req is held until its gnt; gnt is same-cycle, and a
   // granted load returns exactly one rvalid with rdata on the following cycle.

   localparam int BW = bcnt_w(MAX_BURST);
   localparam logic [BW-1:0] MAX_B = BW'(MAX_BURST);

   arb_state_e    state, state_n;
   logic [BW-1:0] bcnt, bcnt_n;
   owner_e        rd_own, rd_own_n;
   owner_e        win_raw, win;
   logic [DW-1:0] core_hold, dbg_hold;

`ifdef DMEM_ARB_RR_EN
   owner_e        last;
`endif

   dmem_arb_pick #(
      .MAX_BURST (MAX_BURST),
      .BW        (BW)
   ) u_pick (
      .state    (state),
      .bcnt     (bcnt),
      .core_req (core_req),
      .dbg_req  (dbg_req),
`ifdef DMEM_ARB_RR_EN
      .last     (last),
`endif
      .win      (win_raw)
   );

   // No grant may leak out while reset is asserted.
   assign win      = RST ? win_raw : NONE;
   assign core_gnt = (win == CORE);
   assign dbg_gnt  = (win == DBG);

   always_comb begin
      mem_en    = 1'b0;
      mem_we    = 1'b0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (win)
         CORE: begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
         end
         DBG: begin
            mem_en    = 1'b1;
            mem_we    = dbg_we;
            mem_addr  = dbg_addr;
            mem_wdata = dbg_wdata;
         end
         default: ;
      endcase
   end

   always_comb begin
      state_n  = state;
      bcnt_n   = bcnt;
      rd_own_n = (mem_en && !mem_we) ? win : NONE;
      if (win == NONE) begin
         state_n = IDLE;
         bcnt_n  = '0;
      end else if ((state == OWN_CORE && win == CORE) ||
                   (state == OWN_DBG  && win == DBG)) begin
         bcnt_n = (bcnt == MAX_B) ? bcnt : bcnt + BW'(1);
      end else begin
         state_n = (win == CORE) ? OWN_CORE : OWN_DBG;
         bcnt_n  = BW'(1);
      end
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state     <= IDLE;
         bcnt      <= '0;
         rd_own    <= NONE;
         core_hold <= '0;
         dbg_hold  <= '0;
      end else begin
         state  <= state_n;
         bcnt   <= bcnt_n;
         rd_own <= rd_own_n;
         if (rd_own == CORE) core_hold <= mem_rdata;
         if (rd_own == DBG)  dbg_hold  <= mem_rdata;
      end
   end

`ifdef DMEM_ARB_RR_EN
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)             last <= DBG;
      else if (win != NONE) last <= win;
   end
`endif

   assign core_rvalid = (rd_own == CORE);
   assign dbg_rvalid  = (rd_own == DBG);
   assign core_rdata  = core_rvalid ? mem_rdata : core_hold;
   assign dbg_rdata   = dbg_rvalid  ? mem_rdata : dbg_hold;
   assign arb_state   = state;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter with a behavioural synchronous dmem model.
module tb_dmem_arbiter;
   import dmem_arb_pkg::*;

   localparam int AW = 5;
   localparam int DW = 32;

   logic          CLK = 1'b0;
   logic          RST = 1'b0;
   logic          core_req = 1'b0, core_we = 1'b0;
   logic [AW-1:0] core_addr = '0;
   logic [DW-1:0] core_wdata = '0;
   logic          core_gnt, core_rvalid;
   logic [DW-1:0] core_rdata;
   logic          dbg_req = 1'b0, dbg_we = 1'b0;
   logic [AW-1:0] dbg_addr = '0;
   logic [DW-1:0] dbg_wdata = '0;
   logic          dbg_gnt, dbg_rvalid;
   logic [DW-1:0] dbg_rdata;
   logic          mem_en, mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata = '0;
   arb_state_e    arb_state;

   int total = 0;
   int bad   = 0;

   logic [DW-1:0] mem [2**AW];

   dmem_arbiter #(.AW(AW), .DW(DW), .MAX_BURST(4)) dut (
      .CLK(CLK), .RST(RST),
      .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
      .core_gnt(core_gnt), .core_rvalid(core_rvalid), .core_rdata(core_rdata),
      .dbg_req(dbg_req), .dbg_we(dbg_we), .dbg_addr(dbg_addr), .dbg_wdata(dbg_wdata),
      .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .arb_state(arb_state)
   );

   always #5 CLK = ~CLK;

   always @(posedge CLK) begin
      if (mem_en) begin
         if (mem_we) mem[mem_addr] <= mem_wdata;
         else        mem_rdata     <= mem[mem_addr];
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic cr, input logic cw, input logic [AW-1:0] ca, input logic [DW-1:0] cd,
                        input logic dr, input logic dw, input logic [AW-1:0] da, input logic [DW-1:0] dd);
      @(negedge CLK);
      core_req = cr; core_we = cw; core_addr = ca; core_wdata = cd;
      dbg_req  = dr; dbg_we  = dw; dbg_addr  = da; dbg_wdata  = dd;
      #1;
   endtask

   logic [8:0] burst_core;
   logic       tie_core;

   initial begin
      burst_core = 9'b1_0000_1111;
`ifdef DMEM_ARB_RR_EN
      tie_core = 1'b0;
`else
      tie_core = 1'b1;
`endif

      // Reset values
      #2;
      chk("rst_core_gnt", core_gnt, 0);
      chk("rst_core_rvalid", core_rvalid, 0);
      chk("rst_dbg_rvalid", dbg_rvalid, 0);
      chk("rst_mem_en", mem_en, 0);
      chk("rst_state", 32'(arb_state), 32'(IDLE));

      // Reset mid-load
      @(negedge CLK); RST = 1'b1;
      drive(1, 0, 5'd0, 0, 0, 0, 0, 0);
      chk("rml_gnt", core_gnt, 1);
      @(negedge CLK);
      RST = 1'b0; core_req = 1'b0;
      #1;
      chk("rml_core_rvalid", core_rvalid, 0);
      chk("rml_core_rdata", core_rdata, 0);
      chk("rml_dbg_rvalid", dbg_rvalid, 0);
      chk("rml_mem_en", mem_en, 0);
      chk("rml_mem_we", mem_we, 0);
      chk("rml_mem_addr", 32'(mem_addr), 0);
      chk("rml_mem_wdata", mem_wdata, 0);
      chk("rml_state", 32'(arb_state), 32'(IDLE));
      @(negedge CLK); RST = 1'b1;
      @(posedge CLK); #1;
      chk("rml_post_rvalid", core_rvalid, 0);
      chk("rml_post_state", 32'(arb_state), 32'(IDLE));

      // Both request continuously: bursts of four
      for (int i = 0; i < 9; i++) begin
         drive(1, 0, AW'(i), 0, 1, 0, AW'(i + 16), 0);
         chk($sformatf("burst_core_gnt_%0d", i), core_gnt, burst_core[i]);
         chk($sformatf("burst_dbg_gnt_%0d", i), dbg_gnt, !burst_core[i]);
      end
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("idle_mem_en", mem_en, 0);

      // IDLE tie after a core grant
      drive(1, 0, 5'd0, 0, 1, 0, 5'd0, 0);
      chk("tie_core_gnt", core_gnt, tie_core);
      chk("tie_dbg_gnt", dbg_gnt, !tie_core);
      drive(0, 0, 0, 0, 0, 0, 0, 0);

      // Core store then load of address 3
      drive(1, 1, 5'd3, 32'hDEADBEEF, 0, 0, 0, 0);
      chk("st_gnt", core_gnt, 1);
      chk("st_mem_we", mem_we, 1);
      chk("st_mem_addr", 32'(mem_addr), 3);
      chk("st_mem_wdata", mem_wdata, 32'hDEADBEEF);
      drive(1, 0, 5'd3, 0, 0, 0, 0, 0);
      chk("ld_gnt", core_gnt, 1);
      chk("ld_mem_we", mem_we, 0);
      chk("ld_rvalid_early", core_rvalid, 0);
      @(posedge CLK); #1;
      chk("ld_rvalid", core_rvalid, 1);
      chk("ld_rdata", core_rdata, 32'hDEADBEEF);
      chk("ld_dbg_rvalid", dbg_rvalid, 0);

      // Core drops while owner, dbg takes over without a bubble
      drive(1, 1, 5'd8, 32'h000000A5, 0, 0, 0, 0);
      chk("hand_core_gnt", core_gnt, 1);
      drive(0, 0, 0, 0, 1, 1, 5'd2, 32'h22222222);
      chk("hand_dbg_gnt", dbg_gnt, 1);
      chk("hand_core_gnt_off", core_gnt, 0);
      chk("hand_mem_en", mem_en, 1);
      chk("hand_mem_addr", 32'(mem_addr), 2);

      // Interleaved loads core@1, dbg@2
      drive(1, 1, 5'd1, 32'h11111111, 0, 0, 0, 0);
      chk("il_st_gnt", core_gnt, 1);
      drive(1, 0, 5'd1, 0, 0, 0, 0, 0);
      chk("il_core_gnt", core_gnt, 1);
      drive(0, 0, 0, 0, 1, 0, 5'd2, 0);
      chk("il_dbg_gnt", dbg_gnt, 1);
      chk("il_core_rvalid", core_rvalid, 1);
      chk("il_core_rdata", core_rdata, 32'h11111111);
      chk("il_dbg_rvalid_off", dbg_rvalid, 0);
      @(posedge CLK); #1;
      chk("il_dbg_rvalid", dbg_rvalid, 1);
      chk("il_dbg_rdata", dbg_rdata, 32'h22222222);
      chk("il_core_rvalid_off", core_rvalid, 0);
      chk("il_core_rdata_hold", core_rdata, 32'h11111111);

      // Debug reads back the core's earlier store
      drive(0, 0, 0, 0, 1, 0, 5'd3, 0);
      @(posedge CLK); #1;
      chk("dbg_ld_rvalid", dbg_rvalid, 1);
      chk("dbg_ld_rdata", dbg_rdata, 32'hDEADBEEF);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      @(posedge CLK); #1;
      chk("end_dbg_rvalid", dbg_rvalid, 0);
      chk("end_dbg_rdata_hold", dbg_rdata, 32'hDEADBEEF);
      chk("end_state", 32'(arb_state), 32'(IDLE));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
